// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin HC-SR04 trigger/echo scheduler driven by a 1 us tick enable.
// Publishes one {id, width, timeout} result per slot on a valid/ready port.
module sonar_scheduler #(
  parameter int NUM_SENSORS = 4,
  parameter int CLK_PER_US  = 40,
  parameter int TRIG_US     = 20,
  parameter int RISE_US     = 1000,
  parameter int MAX_US      = 3600,
  parameter int SLOT_US     = 15000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trig,
  output logic [$clog2(NUM_SENSORS)-1:0] active_id,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(NUM_SENSORS)-1:0] result_id,
  output logic [$clog2(MAX_US+1)-1:0]    result_us,
  output logic                           result_timeout,
  output logic                           result_overrun
);
  localparam int IDW = $clog2(NUM_SENSORS);
  localparam int UW  = $clog2(MAX_US+1);
  localparam int SW  = $clog2(SLOT_US);
  localparam int PRW = $clog2(CLK_PER_US+1);
  localparam int PW  = $clog2(((RISE_US > TRIG_US) ? RISE_US : TRIG_US) + 1);

  typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_RISE, MEASURE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [PRW-1:0]   pre_q;
  logic             tick;
  logic [NUM_SENSORS-1:0] echo_m, echo_s;
  logic             echo_a;
  logic [SW-1:0]    slot_q;
  logic [PW-1:0]    phase_q;
  logic [UW-1:0]    width_q;
  logic [IDW-1:0]   next_id, sel_id;
  logic             start, trig_off, phase_clr, width_set, width_inc, advance;
  logic             publish, pub_to;
  logic [UW-1:0]    pub_us;

  assign tick    = (pre_q == PRW'(CLK_PER_US-1));
  assign echo_a  = echo_s[active_id];
  assign busy    = (state_q != IDLE);
  assign next_id = (active_id == IDW'(NUM_SENSORS-1)) ? '0 : active_id + 1'b1;
  // A slot started straight out of HOLD belongs to the sensor after the current one.
  assign sel_id  = advance ? next_id : active_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    trig_off  = 1'b0;
    phase_clr = 1'b0;
    width_set = 1'b0;
    width_inc = 1'b0;
    advance   = 1'b0;
    publish   = 1'b0;
    pub_to    = 1'b0;
    pub_us    = '0;
    if (tick) begin
      case (state_q)
        IDLE: if (enable) begin
          start   = 1'b1;
          state_d = TRIGGER;
        end
        TRIGGER: if (phase_q == PW'(TRIG_US-1)) begin
          trig_off  = 1'b1;
          phase_clr = 1'b1;
          state_d   = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (echo_a) begin
            width_set = 1'b1;
            state_d   = MEASURE;
          end else if (phase_q == PW'(RISE_US-1)) begin
            publish = 1'b1;
            pub_to  = 1'b1;
            state_d = HOLD;
          end
        end
        MEASURE: begin
          if (!echo_a) begin
            publish = 1'b1;
            pub_us  = width_q;
            state_d = HOLD;
          end else if (width_q == UW'(MAX_US-1)) begin
            publish = 1'b1;
            pub_us  = UW'(MAX_US);
            pub_to  = 1'b1;
            state_d = HOLD;
          end else begin
            width_inc = 1'b1;
          end
        end
        HOLD: if (slot_q == SW'(SLOT_US-1)) begin
          advance = 1'b1;
          if (enable) begin
            start   = 1'b1;
            state_d = TRIGGER;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      active_id <= '0;
      trig      <= '0;
      slot_q    <= '0;
      phase_q   <= '0;
      width_q   <= '0;
    end else begin
      state_q <= state_d;
      if (advance) active_id <= next_id;
      if (start)         trig <= NUM_SENSORS'(1) << sel_id;
      else if (trig_off) trig <= '0;
      // Slot counter saturates so a slot can never wrap past its end.
      if (start) slot_q <= '0;
      else if (tick && busy && slot_q != SW'(SLOT_US-1)) slot_q <= slot_q + 1'b1;
      if (start || phase_clr) phase_q <= '0;
      else if (tick && (state_q == TRIGGER || state_q == WAIT_RISE)) phase_q <= phase_q + 1'b1;
      if (width_set)      width_q <= UW'(1);
      else if (width_inc) width_q <= width_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid   <= 1'b0;
      result_id      <= '0;
      result_us      <= '0;
      result_timeout <= 1'b0;
      result_overrun <= 1'b0;
    end else if (publish) begin
      result_valid   <= 1'b1;
      result_id      <= active_id;
      result_us      <= pub_us;
      result_timeout <= pub_to;
      if (result_valid && !result_ready) result_overrun <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler at scaled timing: per-slot echo plans feed an arithmetic
// result model and a valid/ready port model compared every cycle.
module tb_sonar_scheduler;
  localparam int NS = 4, CPU = 4, TUS = 5, RUS = 40, MUS = 100, SUS = 200;
  localparam int IDW = $clog2(NS), UW = $clog2(MUS+1), SLOT_CYC = SUS*CPU;

  logic clk = 1'b0;
  logic reset, enable, result_ready;
  logic [NS-1:0] echo, trig;
  logic [IDW-1:0] active_id, result_id;
  logic busy, result_valid, result_timeout, result_overrun;
  logic [UW-1:0] result_us;

  sonar_scheduler #(.NUM_SENSORS(NS), .CLK_PER_US(CPU), .TRIG_US(TUS),
                    .RISE_US(RUS), .MAX_US(MUS), .SLOT_US(SUS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .active_id(active_id), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_id(result_id), .result_us(result_us),
    .result_timeout(result_timeout), .result_overrun(result_overrun));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int us; int to; int t; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int exp_id, last_rise, last_fall;
  bit noise_on, rand_ready;
  int cap_id, cap_us, cap_to, cap_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NS-1:0] amask();
    return NS'(1) << exp_id;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (noise_on) echo = (echo & amask()) | (NS'($urandom) & ~amask());
    if (rand_ready) result_ready = ($urandom_range(3) != 0);
  endtask

  // Result port model: one publish per slot at its computed cycle, plus handshake rules.
  initial begin
    int m_valid, m_over, m_id, m_us, m_to;
    bit rdy_prev, dv_prev;
    m_valid = 0; m_over = 0; m_id = 0; m_us = 0; m_to = 0;
    rdy_prev = 0; dv_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_valid = 0; m_over = 0; m_id = 0; m_us = 0; m_to = 0;
        exp_q.delete();
      end else if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        if (m_valid != 0 && !rdy_prev) m_over = 1;
        m_valid = 1;
        m_id = exp_q[0].id; m_us = exp_q[0].us; m_to = exp_q[0].to;
        void'(exp_q.pop_front());
      end else if (m_valid != 0 && rdy_prev) begin
        m_valid = 0;
      end
      check("trig_onehot", int'($countones(trig) <= 1), 1);
      check("result_valid", result_valid, m_valid);
      check("result_overrun", result_overrun, m_over);
      check("result_id", result_id, m_id);
      check("result_us", result_us, m_us);
      check("result_timeout", result_timeout, m_to);
      if (result_valid && !dv_prev) begin
        cap_id = result_id; cap_us = result_us; cap_to = result_timeout; cap_t = cyc;
      end
      dv_prev = result_valid;
      rdy_prev = result_ready;
    end
  end

  // d < 0: no echo. Echo rises d us after trig fall and stays high w us.
  task automatic run_slot(input int d, input int w, input int dis_at);
    int n, j, us, to, hor;
    n = 0;
    while (trig == '0 && n < SLOT_CYC + 20) begin step(); n++; end
    check("trig_start", int'(trig != '0), 1);
    if (trig == '0) return;
    check("trig_id", int'(trig), 1 << exp_id);
    check("active_id", active_id, exp_id);
    check("busy_slot", busy, 1);
    if (last_rise >= 0) check("slot_period", cyc - last_rise, SLOT_CYC);
    last_rise = cyc;
    n = 0;
    while (trig != '0 && n < TUS*CPU + 20) begin step(); n++; end
    check("trig_width", cyc - last_rise, TUS*CPU);
    last_fall = cyc;
    if (d < 0 || d >= RUS) begin us = 0; to = 1; j = RUS; end
    else if (w >= MUS) begin us = MUS; to = 1; j = d + MUS; end
    else begin us = w; to = 0; j = d + w + 1; end
    exp_q.push_back('{exp_id, us, to, last_fall + CPU*j});
    hor = (d >= 0 && d + w > j) ? d + w : j;
    hor = hor + 2;
    for (int k = 0; k <= hor*CPU; k++) begin
      if (d >= 0 && k == d*CPU) echo[exp_id] = 1'b1;
      if (d >= 0 && k == (d+w)*CPU) echo[exp_id] = 1'b0;
      if (dis_at >= 0 && k == dis_at*CPU) enable = 1'b0;
      step();
    end
    exp_id = (exp_id + 1) % NS;
    echo[exp_id] = 1'b0;
  endtask

  task automatic pin(input string tag, input int id, input int us, input int to, input int lat);
    check({tag, "_id"}, cap_id, id);
    check({tag, "_us"}, cap_us, us);
    check({tag, "_timeout"}, cap_to, to);
    check({tag, "_latency"}, cap_t - last_fall, lat);
  endtask

  initial begin
    int n, cat, d, w;
    reset = 1'b1; enable = 1'b0; result_ready = 1'b0; echo = '0;
    noise_on = 0; rand_ready = 0; exp_id = 0; last_rise = -1; last_fall = 0;
    cap_id = -1; cap_us = -1; cap_to = -1; cap_t = -1;
    repeat (4) step();
    check("rst_trig", trig, 0);
    check("rst_active_id", active_id, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", result_overrun, 0);
    reset = 1'b0;
    step();
    enable = 1'b1; result_ready = 1'b1; noise_on = 1;

    run_slot(12, 30, -1);       pin("normal", 0, 30, 0, 172);
    run_slot(-1, 0, -1);        pin("no_echo", 1, 0, 1, 160);
    run_slot(5, 120, -1);       pin("saturate", 2, 100, 1, 420);
    run_slot(RUS-1, MUS-1, -1); pin("late_rise_edge", 3, 99, 0, 556);
    run_slot(RUS, 10, -1);      pin("rise_too_late", 0, 0, 1, 160);
    run_slot(0, MUS, -1);       pin("width_at_max", 1, 100, 1, 400);

    result_ready = 1'b0;
    run_slot(3, 7, -1);
    run_slot(4, 9, -1);
    check("ovr_flag", result_overrun, 1);
    check("ovr_valid", result_valid, 1);
    check("ovr_us", result_us, 9);
    check("ovr_id", result_id, 3);
    result_ready = 1'b1;
    step();
    check("ovr_release_valid", result_valid, 0);
    check("ovr_sticky", result_overrun, 1);

    rand_ready = 1;
    for (int s = 0; s < 12; s++) begin
      cat = $urandom_range(3);
      case (cat)
        0: begin d = -1; w = 0; end
        1: begin d = $urandom_range(RUS-1); w = $urandom_range(MUS-1, 1); end
        2: begin d = $urandom_range(RUS+5, RUS); w = 5; end
        default: begin d = $urandom_range(RUS-1); w = $urandom_range(MUS+15, MUS); end
      endcase
      run_slot(d, w, -1);
    end
    rand_ready = 0; result_ready = 1'b1;

    run_slot(10, 30, 12);
    while (cyc < last_rise + SLOT_CYC + 2) step();
    check("dis_busy", busy, 0);
    check("dis_trig", trig, 0);
    check("dis_active_id", active_id, exp_id);
    repeat (40) step();
    check("dis_stays_idle", int'(trig != '0 || busy), 0);
    enable = 1'b1; last_rise = -1;
    run_slot(8, 20, -1);

    n = 0;
    while (trig == '0 && n < SLOT_CYC + 20) begin step(); n++; end
    check("rst_mid_trig_start", int'(trig != '0), 1);
    step(); step();
    reset = 1'b1;
    #1;
    check("rst_mid_trig_async", trig, 0);
    check("rst_mid_busy", busy, 0);
    repeat (3) step();
    enable = 1'b0;
    reset = 1'b0;
    repeat (10) step();
    check("rst_mid_no_valid", result_valid, 0);
    check("rst_mid_active_id", active_id, 0);
    check("rst_mid_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
